// File: rtl/mvau_weight_stream.sv
// Weight-stream sequencer: sweeps the weight memory NUM_PASSES times per start and
// re-times the registered read data into a backpressure-safe stream with per-pass tlast.
module mvau_weight_stream #(
  parameter int unsigned SIMD         = 2,
  parameter int unsigned TW           = 1,
  parameter int unsigned WMEM_DEPTH   = 4,
  parameter int unsigned WMEM_ADDR_BW = 4,
  parameter int unsigned NUM_PASSES   = 2
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  output logic [SIMD*TW-1:0]      m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int unsigned DW      = SIMD * TW;
  localparam int unsigned PASS_BW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [PASS_BW-1:0]      PASS_LAST = PASS_BW'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WMEM_ADDR_BW-1:0] addr_q;
  logic [PASS_BW-1:0]      pass_q;
  logic                    inflight_q;
  logic                    tag_last_q;
  logic                    tag_final_q;

  logic [1:0]              occ_q;
  logic [DW-1:0]           head_data_q;
  logic                    head_last_q;
  logic                    head_final_q;
  logic [DW-1:0]           tail_data_q;
  logic                    tail_last_q;
  logic                    tail_final_q;

  logic launch_c;
  logic issue_c;
  logic done_c;
  logic pop_c;
  logic push_c;
  logic credit_ok_c;
  logic addr_wrap_c;
  logic pass_last_c;

  assign pop_c       = m_axis_tvalid && m_axis_tready;
  assign push_c      = inflight_q;
  assign addr_wrap_c = (addr_q == ADDR_LAST);
  assign pass_last_c = (pass_q == PASS_LAST);
  // Outstanding words (buffered + in flight, net of this cycle's pop) must stay below FIFO depth.
  assign credit_ok_c = (3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle controls
  always_comb begin
    state_nxt = state;
    launch_c  = 1'b0;
    issue_c   = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          launch_c  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        issue_c = credit_ok_c;
        if (credit_ok_c && addr_wrap_c && pass_last_c) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop_c && head_last_q && head_final_q) begin
          done_c    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address and pass counters; the wrap is explicit so non-power-of-two depths work
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q <= '0;
      pass_q <= '0;
    end else if (launch_c) begin
      addr_q <= '0;
      pass_q <= '0;
    end else if (issue_c) begin
      if (addr_wrap_c) begin
        addr_q <= '0;
        pass_q <= pass_last_c ? '0 : pass_q + PASS_BW'(1);
      end else begin
        addr_q <= addr_q + WMEM_ADDR_BW'(1);
      end
    end
  end

  // Tags follow each read through the memory's one-cycle latency
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inflight_q  <= 1'b0;
      tag_last_q  <= 1'b0;
      tag_final_q <= 1'b0;
    end else begin
      inflight_q  <= issue_c;
      tag_last_q  <= addr_wrap_c;
      tag_final_q <= pass_last_c;
    end
  end

  // Two-entry FIFO; wmem_out is only captured in the cycle after an issue
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      occ_q        <= '0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      head_final_q <= 1'b0;
      tail_data_q  <= '0;
      tail_last_q  <= 1'b0;
      tail_final_q <= 1'b0;
    end else begin
      case ({push_c, pop_c})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_data_q  <= wmem_out;
            head_last_q  <= tag_last_q;
            head_final_q <= tag_final_q;
          end else begin
            tail_data_q  <= wmem_out;
            tail_last_q  <= tag_last_q;
            tail_final_q <= tag_final_q;
          end
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_data_q  <= tail_data_q;
          head_last_q  <= tail_last_q;
          head_final_q <= tail_final_q;
          occ_q        <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            head_data_q  <= wmem_out;
            head_last_q  <= tag_last_q;
            head_final_q <= tag_final_q;
          end else begin
            head_data_q  <= tail_data_q;
            head_last_q  <= tail_last_q;
            head_final_q <= tail_final_q;
            tail_data_q  <= wmem_out;
            tail_last_q  <= tag_last_q;
            tail_final_q <= tag_final_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != S_IDLE);
  assign done          = done_c;
  assign wmem_addr     = addr_q;
  assign m_axis_tdata  = head_data_q;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tlast  = m_axis_tvalid && head_last_q;

  fifo_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    !(push_c && !pop_c && (occ_q == 2'd2)));

endmodule

// File: tb/tb_mvau_weight_stream.sv
// Bench for mvau_weight_stream: three instances (1, 3 and 4 passes) share stimulus;
// a per-instance scoreboard checks every presented word plus table-driven cycle checks.
module tb_mvau_weight_stream;

  localparam int SIMD  = 4;
  localparam int TW    = 2;
  localparam int DW    = SIMD * TW;
  localparam int DEPTH = 4;
  localparam int ABW   = 4;
  localparam int NI    = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } beat_t;

  typedef struct packed {
    logic           tready;
    logic           busy;
    logic           done;
    logic           tvalid;
    logic           tlast;
    logic [DW-1:0]  tdata;
    logic [ABW-1:0] addr;
  } vec_t;

  logic           aclk = 1'b0;
  logic           areset;
  logic           start;
  logic           tready;
  logic [NI-1:0]  busy;
  logic [NI-1:0]  done;
  logic [NI-1:0]  tvalid;
  logic [NI-1:0]  tlast;
  logic [DW-1:0]  tdata [NI];
  logic [ABW-1:0] addr [NI];
  logic [DW-1:0]  mem [DEPTH];

  beat_t exp_q [NI][$];
  int    exp_done [NI];
  int    done_cnt [NI];
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vec [8];

  always #5 aclk = ~aclk;

  function automatic int passes_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] rd_q;
    // Registered memory that re-reads every cycle
    always @(posedge aclk) rd_q <= mem[addr[g][1:0]];

    mvau_weight_stream #(
      .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW),
      .NUM_PASSES((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .aclk          (aclk),
      .areset        (areset),
      .start         (start),
      .busy          (busy[g]),
      .done          (done[g]),
      .wmem_addr     (addr[g]),
      .wmem_out      (rd_q),
      .m_axis_tdata  (tdata[g]),
      .m_axis_tvalid (tvalid[g]),
      .m_axis_tlast  (tlast[g]),
      .m_axis_tready (tready)
    );
  end

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic push_run();
    for (int g = 0; g < NI; g++) begin
      for (int p = 0; p < passes_of(g); p++) begin
        for (int a = 0; a < DEPTH; a++) begin
          exp_q[g].push_back('{data: mem[a], last: (a == DEPTH - 1),
                               fin: (a == DEPTH - 1) && (p == passes_of(g) - 1)});
        end
      end
      exp_done[g]++;
    end
  endtask

  // Scoreboard sample for one cycle, away from the rising edge
  task automatic observe();
    @(negedge aclk);
    if (!areset) begin
      for (int g = 0; g < NI; g++) begin
        beat_t e;
        logic  fin;
        fin = 1'b0;
        if (tvalid[g]) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat[%0d]: unexpected word 0x%0h, expected no valid", g, tdata[g]);
          end else begin
            e = exp_q[g][0];
            check($sformatf("tdata[%0d]", g), 32'(tdata[g]), 32'(e.data));
            check($sformatf("tlast[%0d]", g), 32'(tlast[g]), 32'(e.last));
            if (tready) begin
              e   = exp_q[g].pop_front();
              fin = e.fin;
            end
          end
        end
        check($sformatf("done[%0d]", g), 32'(done[g]), 32'(fin));
        if (done[g]) done_cnt[g]++;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy != '0 && n < budget) begin
      observe();
      next_cycle();
      n++;
    end
    check("idle_within_budget", 32'(busy), 32'(0));
    for (int g = 0; g < NI; g++) begin
      check($sformatf("sb_empty[%0d]", g), 32'(exp_q[g].size()), 32'(0));
      check($sformatf("done_count[%0d]", g), 32'(done_cnt[g]), 32'(exp_done[g]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_busy[%0d]", tag, g), 32'(busy[g]), 32'(0));
      check($sformatf("%s_done[%0d]", tag, g), 32'(done[g]), 32'(0));
      check($sformatf("%s_tvalid[%0d]", tag, g), 32'(tvalid[g]), 32'(0));
      check($sformatf("%s_tlast[%0d]", tag, g), 32'(tlast[g]), 32'(0));
      check($sformatf("%s_tdata[%0d]", tag, g), 32'(tdata[g]), 32'(0));
      check($sformatf("%s_addr[%0d]", tag, g), 32'(addr[g]), 32'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    mem[3] = 8'hD4;
    // Single-pass instance, tready=1, start in cycle 0
    vec[0] = '{tready: 1'b1, busy: 1'b0, done: 1'b0, tvalid: 1'b0, tlast: 1'b0, tdata: 8'h00, addr: 4'd0};
    vec[1] = '{tready: 1'b1, busy: 1'b1, done: 1'b0, tvalid: 1'b0, tlast: 1'b0, tdata: 8'h00, addr: 4'd0};
    vec[2] = '{tready: 1'b1, busy: 1'b1, done: 1'b0, tvalid: 1'b0, tlast: 1'b0, tdata: 8'h00, addr: 4'd1};
    vec[3] = '{tready: 1'b1, busy: 1'b1, done: 1'b0, tvalid: 1'b1, tlast: 1'b0, tdata: 8'hA1, addr: 4'd2};
    vec[4] = '{tready: 1'b1, busy: 1'b1, done: 1'b0, tvalid: 1'b1, tlast: 1'b0, tdata: 8'hB2, addr: 4'd3};
    vec[5] = '{tready: 1'b1, busy: 1'b1, done: 1'b0, tvalid: 1'b1, tlast: 1'b0, tdata: 8'hC3, addr: 4'd0};
    vec[6] = '{tready: 1'b1, busy: 1'b1, done: 1'b1, tvalid: 1'b1, tlast: 1'b1, tdata: 8'hD4, addr: 4'd0};
    vec[7] = '{tready: 1'b1, busy: 1'b0, done: 1'b0, tvalid: 1'b0, tlast: 1'b0, tdata: 8'h00, addr: 4'd0};
    for (int g = 0; g < NI; g++) begin
      exp_done[g] = 0;
      done_cnt[g] = 0;
    end

    areset = 1'b1;
    start  = 1'b0;
    tready = 1'b0;
    next_cycle();
    next_cycle();
    check_reset_outputs("reset");
    areset = 1'b0;
    next_cycle();
    next_cycle();

    // Table run; the 3- and 4-pass instances must stream without gaps
    for (int c = 0; c < 20; c++) begin
      start  = (c == 0);
      tready = (c < 8) ? vec[c].tready : 1'b1;
      if (c == 0) push_run();
      observe();
      if (c < 8) begin
        check($sformatf("t1_busy_c%0d", c), 32'(busy[0]), 32'(vec[c].busy));
        check($sformatf("t1_done_c%0d", c), 32'(done[0]), 32'(vec[c].done));
        check($sformatf("t1_tvalid_c%0d", c), 32'(tvalid[0]), 32'(vec[c].tvalid));
        check($sformatf("t1_tlast_c%0d", c), 32'(tlast[0]), 32'(vec[c].tlast));
        check($sformatf("t1_addr_c%0d", c), 32'(addr[0]), 32'(vec[c].addr));
        if (vec[c].tvalid) check($sformatf("t1_tdata_c%0d", c), 32'(tdata[0]), 32'(vec[c].tdata));
      end
      check($sformatf("nogap3_c%0d", c), 32'(tvalid[1]), 32'(c >= 3 && c <= 14));
      check($sformatf("nogap4_c%0d", c), 32'(tvalid[2]), 32'(c >= 3 && c <= 18));
      check($sformatf("busy3_c%0d", c), 32'(busy[1]), 32'(c >= 1 && c <= 14));
      next_cycle();
    end
    start = 1'b0;
    wait_idle(50);

    // Backpressure: tready low in cycles 3..10
    for (int c = 0; c < 14; c++) begin
      start  = (c == 0);
      tready = !(c >= 3 && c <= 10);
      if (c == 0) push_run();
      observe();
      if (c >= 3 && c <= 11) begin
        check($sformatf("bp_tvalid_c%0d", c), 32'(tvalid[0]), 32'(1));
        check($sformatf("bp_tdata_c%0d", c), 32'(tdata[0]), 32'(mem[0]));
        check($sformatf("bp_addr_c%0d", c), 32'(addr[0]), 32'(2));
      end
      if (c >= 4 && c <= 10)
        check($sformatf("bp_occ_c%0d", c), 32'(g_dut[0].u_dut.occ_q), 32'(2));
      next_cycle();
    end
    start  = 1'b0;
    tready = 1'b1;
    wait_idle(100);

    // Random tready
    start  = 1'b1;
    tready = 1'($urandom_range(0, 1));
    push_run();
    observe();
    next_cycle();
    start = 1'b0;
    n = 0;
    while (busy != '0 && n < 600) begin
      tready = 1'($urandom_range(0, 1));
      observe();
      next_cycle();
      n++;
    end
    tready = 1'b1;
    wait_idle(20);

    // Second start while busy is ignored
    for (int c = 0; c < 8; c++) begin
      start = (c == 0 || c == 4);
      if (c == 0) push_run();
      observe();
      next_cycle();
    end
    start = 1'b0;
    wait_idle(100);

    // Reset in cycle 5 of a run
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      if (c == 0) push_run();
      observe();
      next_cycle();
    end
    start  = 1'b0;
    areset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    for (int g = 0; g < NI; g++) begin
      exp_q[g].delete();
      exp_done[g]--;
    end
    observe();
    next_cycle();
    next_cycle();
    areset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      observe();
      check($sformatf("post_reset_busy_c%0d", c), 32'(busy), 32'(0));
      check($sformatf("post_reset_tvalid_c%0d", c), 32'(tvalid), 32'(0));
      next_cycle();
    end
    for (int c = 0; c < 5; c++) begin
      start = (c == 0);
      if (c == 0) push_run();
      observe();
      check($sformatf("restart_tvalid_c%0d", c), 32'(tvalid[0]), 32'(c >= 3));
      if (c == 3) check("restart_first_word", 32'(tdata[0]), 32'(mem[0]));
      next_cycle();
    end
    start = 1'b0;
    wait_idle(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
